gpio_in_ip: RTL and testbench
=============================

// Module: gpio_in_ip
// PURPOSE
//  Input-direction companion to the GPIO output block. Samples up to 32 external input pins,
//  synchronises them to clk and detects per-pin edges. Edges are latched into sticky status bits,
//  and a maskable interrupt is raised from them. Uses the same simple register bus as the
//  output block: write_en/read_en/wdata/rdata plus a 2-bit addr.
// PARAMETERS
//  WIDTH        32  number of input pins (1..32)
//  SYNC_STAGES  2   synchroniser flops per pin (>=2)
//  DEB_CYCLES   4   stable cycles needed before a pin value is accepted (debounce build only, >=2)
// PORTS
//  clk       in   1      system clock, all logic on rising edge
//  resetn    in   1      asynchronous active-low reset
//  write_en  in   1      register write strobe, one cycle per write
//  read_en   in   1      register read strobe
//  addr      in   2      register select
//  wdata     in   32     write data; bits [WIDTH-1:0] used
//  rdata     out  32     registered read data; bits above WIDTH read 0
//  gpio_in   in   WIDTH  asynchronous external pins
//  irq       out  1      registered interrupt, level, active-high
// BEHAVIOUR
//  Register map (addr):
//   0 IN_VAL   RO   filtered pin value; writes ignored
//   1 STATUS   W1C  sticky edge flags; writing 1 clears that bit, writing 0 has no effect
//   2 IRQ_EN   RW   per-pin interrupt mask, 1 = enabled
//   3 EDGE_SEL RW   per-pin edge polarity, 1 = rising, 0 = falling
//  Reset (async, resetn=0):
//   - all synchroniser flops, prev, STATUS, IRQ_EN, EDGE_SEL, rdata and irq clear to 0
//   - debounce counters and stable value also clear to 0
//   - reset mid-operation discards in-flight edges; no edge is flagged for pins already high
//     on the first cycle after release until they are seen low
//  Sync: SYNC_STAGES-flop chain per pin; sync_out is the last stage.
//  Edge: filt = sync_out (or debounced value); prev <= filt each cycle.
//   - rise = filt & ~prev; fall = ~filt & prev
//   - hit  = EDGE_SEL ? rise : fall (per pin)
//  STATUS update each cycle: STATUS <= (STATUS & ~clr) | hit, where clr = wdata when
//   write_en && addr==1, else 0.
//   - Simultaneous hit and clear on the same bit: set wins (bit stays 1).
//  Latency, non-debounce build (gpio_in changes before sampling edge E1):
//   - IN_VAL reflects the change after edge E(SYNC_STAGES)
//   - STATUS bit set after E(SYNC_STAGES+1)
//   - irq high after E(SYNC_STAGES+2)
//  irq <= |(STATUS & IRQ_EN), registered.
//   - Falls one cycle after the last enabled flag clears or its mask is cleared.
//  Read: when read_en, rdata <= selected register at that edge; valid the next cycle.
//   - rdata holds its value while read_en=0.
//  read_en and write_en in the same cycle: write takes effect and rdata returns the pre-write value.
//  Writes to IRQ_EN/EDGE_SEL take effect from the following cycle.
//   - An EDGE_SEL change never manufactures an edge by itself.
// CONFIGURATION
//  GPIO_IN_DEBOUNCE_EN defined: per-pin counter cnt[$clog2(DEB_CYCLES)-1:0] and stable value stb.
//   - If sync_out==stb: cnt <= 0.
//   - Else if cnt==DEB_CYCLES-1: stb <= sync_out, cnt <= 0.
//   - Else cnt <= cnt+1.
//   - filt = stb, adding DEB_CYCLES cycles of latency.
//   - A pulse shorter than DEB_CYCLES cycles at sync_out is never seen.
//  Undefined: no counters; filt = sync_out; DEB_CYCLES is unused.
// TESTING
//  1 Reset: resetn=0 with gpio_in=FFFFFFFF -> rdata=0, irq=0; IN_VAL reads 0 until released.
//  2 Rise: EDGE_SEL=00000001, IRQ_EN=00000001; drive gpio_in[0] 0->1 -> STATUS=00000001 at
//    E3 and irq=1 at E4 (SYNC_STAGES=2); IN_VAL=00000001.
//  3 Fall and mask: EDGE_SEL=0, IRQ_EN=0; drive gpio_in[4] 1->0 -> STATUS bit4=1 and irq stays 0;
//    write IRQ_EN=00000010 -> irq=1 next cycle.
//  4 W1C race: write STATUS=FFFFFFFF in the same cycle bit0 sees a rising hit -> STATUS=00000001;
//    the next clear gives 0 and irq drops one cycle later.
//  5 Readback: write IRQ_EN=DEADBEEF with read_en=1 on addr 2 -> first rdata is the old value;
//    the next read returns DEADBEEF (WIDTH=32).
//  6 Debounce (GPIO_IN_DEBOUNCE_EN, DEB_CYCLES=4):
//    - a 2-cycle high glitch on gpio_in[1] -> no STATUS change
//    - a 10-cycle high on gpio_in[1] -> IN_VAL bit1=1 four cycles later than the non-debounce build

Source files
------------

// File: rtl/gpio_in_ip.sv
// gpio_in_ip: input-direction GPIO block.
// Each pin passes through a synchroniser, an optional debounce filter and an
// edge detector. Edges are latched into sticky W1C status bits, and a maskable
// level interrupt is raised from those bits. Everything sits behind a small
// register bus (write_en/read_en/addr/wdata/rdata).
//
// Build option: define GPIO_IN_DEBOUNCE_EN to add a per-pin debounce filter.
// With the filter, a pin value must hold for DEB_CYCLES cycles before it is
// accepted. Without the filter, the synchroniser output feeds the edge
// detector directly.
//
// Register map:
//   0 IN_VAL   RO   filtered pin value
//   1 STATUS   W1C  sticky edge flags
//   2 IRQ_EN   RW   per-pin interrupt enable
//   3 EDGE_SEL RW   per-pin polarity, 1 = rising, 0 = falling
module gpio_in_ip #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             write_en,
  input  logic             read_en,
  input  logic [1:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic             irq
);

  localparam logic [1:0] A_IN_VAL   = 2'd0;
  localparam logic [1:0] A_STATUS   = 2'd1;
  localparam logic [1:0] A_IRQ_EN   = 2'd2;
  localparam logic [1:0] A_EDGE_SEL = 2'd3;

  localparam int FILL_W = $clog2(SYNC_STAGES + 1);

  // Reject unusable parameter values at elaboration time.
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("gpio_in_ip: WIDTH must be 1..32");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("gpio_in_ip: SYNC_STAGES must be >= 2");
  end
  if (DEB_CYCLES < 2) begin : g_bad_deb
    $error("gpio_in_ip: DEB_CYCLES must be >= 2");
  end

  // Zero-extend a pin-wide value onto the 32-bit read bus.
  function automatic logic [31:0] f_pad(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  logic [WIDTH-1:0]  r_sync [SYNC_STAGES];
  logic [FILL_W-1:0] r_fill;
  logic [WIDTH-1:0]  r_prev;
  logic [WIDTH-1:0]  r_armed;
  logic [WIDTH-1:0]  r_status;
  logic [WIDTH-1:0]  r_irq_en;
  logic [WIDTH-1:0]  r_edge_sel;
  logic [31:0]       r_rdata;
  logic              r_irq;

  logic [WIDTH-1:0]  w_sync_out;
  logic [WIDTH-1:0]  w_filt;
  logic [WIDTH-1:0]  w_low_seen;
  logic              w_fill_done;
  logic [WIDTH-1:0]  w_rise;
  logic [WIDTH-1:0]  w_fall;
  logic [WIDTH-1:0]  w_hit;
  logic [WIDTH-1:0]  w_clr;
  logic              w_wr_status;
  logic              w_wr_irq_en;
  logic              w_wr_edge_sel;

  assign w_sync_out = r_sync[SYNC_STAGES-1];

  // Synchroniser chain: stage 0 samples the asynchronous pins.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  // Counts edges after reset release until the synchroniser holds real samples.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_fill <= '0;
    end else if (!w_fill_done) begin
      r_fill <= r_fill + FILL_W'(1);
    end
  end

  assign w_fill_done = (r_fill == FILL_W'(SYNC_STAGES));

`ifdef GPIO_IN_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEB_CYCLES);

  logic [CNT_W-1:0] r_cnt [WIDTH];
  logic [WIDTH-1:0] r_stb;

  // Debounce: accept a new pin value only after DEB_CYCLES cycles of disagreement.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int p = 0; p < WIDTH; p++) r_cnt[p] <= '0;
      r_stb <= '0;
    end else begin
      for (int p = 0; p < WIDTH; p++) begin
        if (w_sync_out[p] == r_stb[p]) begin
          r_cnt[p] <= '0;
        end else if (r_cnt[p] == CNT_W'(DEB_CYCLES - 1)) begin
          r_stb[p] <= w_sync_out[p];
          r_cnt[p] <= '0;
        end else begin
          r_cnt[p] <= r_cnt[p] + CNT_W'(1);
        end
      end
    end
  end

  assign w_filt     = r_stb;
  // A pin counts as really low only when both the filter and the raw sample agree.
  assign w_low_seen = ~r_stb & ~w_sync_out;
`else
  assign w_filt     = w_sync_out;
  assign w_low_seen = ~w_sync_out;
`endif

  // A rising edge is honoured only after the pin has been observed low since
  // reset. This stops pins that are already high at release from flagging.
  assign w_rise = w_filt & ~r_prev & r_armed;
  assign w_fall = ~w_filt & r_prev;
  assign w_hit  = (r_edge_sel & w_rise) | (~r_edge_sel & w_fall);

  assign w_wr_status   = write_en && (addr == A_STATUS);
  assign w_wr_irq_en   = write_en && (addr == A_IRQ_EN);
  assign w_wr_edge_sel = write_en && (addr == A_EDGE_SEL);
  assign w_clr         = w_wr_status ? wdata[WIDTH-1:0] : '0;

  // Edge history, arming and sticky status; a hit wins over a clear on the same bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_prev   <= '0;
      r_armed  <= '0;
      r_status <= '0;
    end else begin
      r_prev   <= w_filt;
      r_armed  <= r_armed | (w_fill_done ? w_low_seen : '0);
      r_status <= (r_status & ~w_clr) | w_hit;
    end
  end

  // Software-written configuration registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_irq_en   <= '0;
      r_edge_sel <= '0;
    end else begin
      if (w_wr_irq_en)   r_irq_en   <= wdata[WIDTH-1:0];
      if (w_wr_edge_sel) r_edge_sel <= wdata[WIDTH-1:0];
    end
  end

  // Registered level interrupt from any enabled sticky flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(r_status & r_irq_en);
    end
  end

  // Read port: capture the pre-write register value on read_en, hold otherwise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rdata <= '0;
    end else if (read_en) begin
      case (addr)
        A_IN_VAL:   r_rdata <= f_pad(w_filt);
        A_STATUS:   r_rdata <= f_pad(r_status);
        A_IRQ_EN:   r_rdata <= f_pad(r_irq_en);
        A_EDGE_SEL: r_rdata <= f_pad(r_edge_sel);
        default:    r_rdata <= '0;
      endcase
    end
  end

  assign rdata = r_rdata;
  assign irq   = r_irq;

endmodule

// File: tb/tb_gpio_in_ip.sv
// Testbench for gpio_in_ip. Register reads push their expected value onto a
// scoreboard queue; a monitor pops and compares once rdata is valid.
// Interrupt and hold checks compare directly against bench constants.
module tb_gpio_in_ip;

  localparam int WIDTH       = 32;
  localparam int SYNC_STAGES = 2;
  localparam int DEB_CYCLES  = 4;
`ifdef GPIO_IN_DEBOUNCE_EN
  localparam int DEB_LAT = DEB_CYCLES;
`else
  localparam int DEB_LAT = 0;
`endif
  // Edge at which IN_VAL first reflects a pin change made before E1.
  localparam int LAT  = SYNC_STAGES + DEB_LAT;
  localparam int SETL = LAT + 4;

  logic             clk;
  logic             resetn;
  logic             write_en;
  logic             read_en;
  logic [1:0]       addr;
  logic [31:0]      wdata;
  logic [31:0]      rdata;
  logic [WIDTH-1:0] gpio_in;
  logic             irq;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } rd_t;
  rd_t sb_q[$];

  gpio_in_ip #(
    .WIDTH(WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .DEB_CYCLES(DEB_CYCLES)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .write_en(write_en),
    .read_en(read_en),
    .addr(addr),
    .wdata(wdata),
    .rdata(rdata),
    .gpio_in(gpio_in),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    write_en = 1'b1;
    addr     = a;
    wdata    = d;
    tick();
    write_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    rd_t e;
    e.tag   = tag;
    e.exp   = exp;
    sb_q.push_back(e);
    read_en = 1'b1;
    addr    = a;
    tick();
    read_en = 1'b0;
  endtask

  // Monitor: every edge that sees read_en makes rdata valid before the next negedge.
  initial begin
    forever begin
      @(posedge clk);
      if (read_en && resetn) begin
        @(negedge clk);
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          rd_t e;
          e = sb_q.pop_front();
          chk(e.tag, rdata, e.exp);
        end
      end
    end
  end

  initial begin
    resetn   = 1'b0;
    write_en = 1'b0;
    read_en  = 1'b0;
    addr     = 2'd0;
    wdata    = '0;
    gpio_in  = '1;

    // Reset with all pins high; a read strobe during reset must not load rdata.
    repeat (3) tick();
    read_en = 1'b1;
    tick();
    read_en = 1'b0;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'h0);

    // Release with pins high: no rising flags, even with rising polarity selected.
    resetn = 1'b1;
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd0, 32'h0, "inval_after_release");
    repeat (SETL) tick();
    rd(2'd1, 32'h0, "no_flag_high_at_release");
    rd(2'd0, 32'hFFFF_FFFF, "inval_all_high");
    gpio_in = '0;
    repeat (SETL) tick();
    rd(2'd1, 32'h0, "no_flag_on_fall_rise_sel");
    wr(2'd3, 32'h0);
    tick();
    rd(2'd1, 32'h0, "edge_sel_change_no_edge");

    // Rising edge on pin 0: latency to IN_VAL, STATUS and irq.
    wr(2'd3, 32'h0000_0001);
    wr(2'd2, 32'h0000_0001);
    gpio_in[0] = 1'b1;
    repeat (LAT - 1) tick();
    rd(2'd0, 32'h0, "inval_before_lat");
    rd(2'd0, 32'h1, "inval_at_lat");
    chk("irq_before", {31'd0, irq}, 32'h0);
    tick();
    chk("irq_rise", {31'd0, irq}, 32'h1);
    rd(2'd1, 32'h1, "status_rise");

    // Falling edge on pin 4 with the mask off, then enabled.
    wr(2'd1, 32'hFFFF_FFFF);
    wr(2'd3, 32'h0);
    wr(2'd2, 32'h0);
    gpio_in[4] = 1'b1;
    repeat (SETL) tick();
    chk("irq_cleared", {31'd0, irq}, 32'h0);
    gpio_in[4] = 1'b0;
    repeat (SETL) tick();
    rd(2'd1, 32'h0000_0010, "status_fall");
    chk("irq_masked", {31'd0, irq}, 32'h0);
    wr(2'd2, 32'h0000_0010);
    chk("irq_mask_same", {31'd0, irq}, 32'h0);
    tick();
    chk("irq_unmasked", {31'd0, irq}, 32'h1);

    // Clear racing a rising hit on pin 0: the hit survives.
    wr(2'd3, 32'h0000_0001);
    wr(2'd2, 32'h0000_0001);
    gpio_in[0] = 1'b0;
    repeat (SETL) tick();
    wr(2'd1, 32'hFFFF_FFFF);
    tick();
    rd(2'd1, 32'h0, "status_pre_race");
    gpio_in[0] = 1'b1;
    repeat (LAT) tick();
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1, 32'h1, "w1c_race_set_wins");
    chk("irq_race", {31'd0, irq}, 32'h1);
    wr(2'd1, 32'h0000_0001);
    chk("irq_hold_after_clr", {31'd0, irq}, 32'h1);
    tick();
    chk("irq_drop", {31'd0, irq}, 32'h0);
    rd(2'd1, 32'h0, "status_cleared");

    // Read and write together: the read returns the pre-write value.
    write_en = 1'b1;
    wdata    = 32'hDEAD_BEEF;
    rd(2'd2, 32'h0000_0001, "rw_old_value");
    write_en = 1'b0;
    rd(2'd2, 32'hDEAD_BEEF, "irq_en_readback");
    rd(2'd3, 32'h0000_0001, "edge_sel_readback");
    repeat (3) tick();
    chk("rdata_hold", rdata, 32'h0000_0001);
    wr(2'd0, 32'h1234_5678);
    rd(2'd0, 32'h0000_0001, "inval_ro");

`ifdef GPIO_IN_DEBOUNCE_EN
    // Short glitch is filtered out; a long pulse passes with extra latency.
    wr(2'd3, 32'h0000_0003);
    gpio_in[1] = 1'b1;
    repeat (2) tick();
    gpio_in[1] = 1'b0;
    repeat (SETL) tick();
    rd(2'd1, 32'h0, "deb_glitch");
    gpio_in[1] = 1'b1;
    repeat (LAT - 1) tick();
    rd(2'd0, 32'h0000_0001, "deb_before_lat");
    rd(2'd0, 32'h0000_0003, "deb_at_lat");
    repeat (10 - LAT - 1) tick();
    gpio_in[1] = 1'b0;
    repeat (SETL) tick();
    rd(2'd1, 32'h0000_0002, "deb_long_flag");
`endif

    // Bounded drain of outstanding reads.
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) tick();
    chk("sb_drain", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
